// File: rtl/ra_pkg.sv
// Shared definitions for the region-array writer: control-word layout,
// list-type field positions, FSM states and the OPB stride helper.
package ra_pkg;

  localparam int CTRL_LAST_BIT   = 31;
  localparam int CTRL_ZCLEAR_BIT = 30;
  localparam int CTRL_FLUSH_BIT  = 28;
  localparam int CTRL_Y_MSB      = 13;
  localparam int CTRL_Y_LSB      = 8;
  localparam int CTRL_X_MSB      = 7;
  localparam int CTRL_X_LSB      = 2;

  localparam logic [31:0] UNUSED_MARKER = 32'h8000_0000;

  localparam int FMT_V2_BIT = 21;

  // List order matches the write order inside one entry.
  localparam int NUM_LISTS = 5;
  localparam int LIST_O    = 0;
  localparam int LIST_OM   = 1;
  localparam int LIST_T    = 2;
  localparam int LIST_TM   = 3;
  localparam int LIST_PT   = 4;

  localparam int OPB_LSB_O  = 0;
  localparam int OPB_LSB_OM = 4;
  localparam int OPB_LSB_T  = 8;
  localparam int OPB_LSB_TM = 12;
  localparam int OPB_LSB_PT = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CTRL,
    ST_OPQ,
    ST_OPQM,
    ST_TRN,
    ST_TRNM,
    ST_PT,
    ST_NEXT,
    ST_DONE
  } ra_state_e;

  typedef logic [NUM_LISTS-1:0][1:0]  opb_vec_t;
  typedef logic [NUM_LISTS-1:0][23:0] ptr_vec_t;

  // A disabled list (size code 0) gets a zero stride so its pointer holds.
  function automatic logic [23:0] opb_stride(input logic [1:0] opb);
    return (opb == 2'd0) ? 24'd0 : (24'd16 << opb);
  endfunction

  function automatic opb_vec_t opb_fields(input logic [31:0] ta);
    opb_vec_t f;
    f[LIST_O]  = ta[OPB_LSB_O  +: 2];
    f[LIST_OM] = ta[OPB_LSB_OM +: 2];
    f[LIST_T]  = ta[OPB_LSB_T  +: 2];
    f[LIST_TM] = ta[OPB_LSB_TM +: 2];
    f[LIST_PT] = ta[OPB_LSB_PT +: 2];
    return f;
  endfunction

  function automatic logic [31:0] ctrl_word(input logic last, input logic zclear,
                                            input logic flush, input logic [5:0] x,
                                            input logic [5:0] y);
    logic [31:0] w;
    w = '0;
    w[CTRL_LAST_BIT]             = last;
    w[CTRL_ZCLEAR_BIT]           = zclear;
    w[CTRL_FLUSH_BIT]            = flush;
    w[CTRL_Y_MSB:CTRL_Y_LSB]     = y;
    w[CTRL_X_MSB:CTRL_X_LSB]     = x;
    return w;
  endfunction

endpackage

// File: rtl/ra_list_ptr.sv
// Running OPB pointers for the five list types; each advances by its own
// stride once per tile and wraps within the 24-bit VRAM space.
module ra_list_ptr
  import ra_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     load,
  input  logic     advance,
  input  ptr_vec_t base,
  input  opb_vec_t opb,
  output ptr_vec_t ptr
);

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= base;
    end else if (advance) begin
      for (int i = 0; i < NUM_LISTS; i++) begin
        ptr[i] <= ptr[i] + opb_stride(opb[i]);
      end
    end
  end

endmodule

// File: rtl/ra_writer.sv
// Region-array writer: walks the tile grid in raster order and emits one
// control word plus four or five list words per tile into VRAM.
module ra_writer
  import ra_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        ra_gen_trig,
  input  logic [31:0] REGION_BASE,
  input  logic [31:0] FPU_PARAM_CFG,
  input  logic [31:0] TA_ALLOC_CTRL,
  input  logic [23:0] o_list_base,
  input  logic [23:0] om_list_base,
  input  logic [23:0] t_list_base,
  input  logic [23:0] tm_list_base,
  input  logic [23:0] pt_list_base,
  input  logic [5:0]  tile_x_max,
  input  logic [5:0]  tile_y_max,
  input  logic        cont_zclear,
  input  logic        cont_flush,
  output logic        ra_vram_wr,
  output logic [23:0] ra_vram_addr,
  output logic [31:0] ra_vram_dout,
  input  logic        ra_vram_busy,
  output logic        ra_gen_busy,
  output logic        ra_gen_done,
  output ra_state_e   dbg_state
);

  ra_state_e state;
  logic [5:0] x, y, x_max, y_max;
  logic       fmt_v2, zclear_q, flush_q;
  opb_vec_t   opb_q;
  ptr_vec_t   base_vec, ptr;
  logic [NUM_LISTS-1:0][31:0] list_word;
  logic       load, advance, accept, last_tile, next_last;
  logic [5:0] nx, ny;

  assign dbg_state = state;
  assign load      = (state == ST_IDLE) && ra_gen_trig;
  assign advance   = (state == ST_NEXT);

  // Handshake: a write holds addr/dout stable while ra_vram_wr=1 and
  // completes on the first rising edge where ra_vram_busy=0.
  assign accept = ra_vram_wr && !ra_vram_busy;

  always_comb begin
    base_vec          = '0;
    base_vec[LIST_O]  = o_list_base;
    base_vec[LIST_OM] = om_list_base;
    base_vec[LIST_T]  = t_list_base;
    base_vec[LIST_TM] = tm_list_base;
    base_vec[LIST_PT] = pt_list_base;
    for (int i = 0; i < NUM_LISTS; i++) begin
      list_word[i] = (opb_q[i] == 2'd0) ? UNUSED_MARKER : {8'h00, ptr[i]};
    end
  end

  always_comb begin
    last_tile = (x == x_max) && (y == y_max);
    if (x == x_max) begin
      nx = 6'd0;
      ny = y + 6'd1;
    end else begin
      nx = x + 6'd1;
      ny = y;
    end
    next_last = (nx == x_max) && (ny == y_max);
  end

  ra_list_ptr u_list_ptr (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .advance (advance),
    .base    (base_vec),
    .opb     (opb_q),
    .ptr     (ptr)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      x            <= '0;
      y            <= '0;
      x_max        <= '0;
      y_max        <= '0;
      fmt_v2       <= 1'b0;
      zclear_q     <= 1'b0;
      flush_q      <= 1'b0;
      opb_q        <= '0;
      ra_vram_wr   <= 1'b0;
      ra_vram_addr <= '0;
      ra_vram_dout <= '0;
      ra_gen_busy  <= 1'b0;
      ra_gen_done  <= 1'b0;
    end else begin
      ra_gen_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ra_gen_trig) begin
            x            <= '0;
            y            <= '0;
            x_max        <= tile_x_max;
            y_max        <= tile_y_max;
            fmt_v2       <= FPU_PARAM_CFG[FMT_V2_BIT];
            zclear_q     <= cont_zclear;
            flush_q      <= cont_flush;
            opb_q        <= opb_fields(TA_ALLOC_CTRL);
            ra_gen_busy  <= 1'b1;
            ra_vram_wr   <= 1'b1;
            ra_vram_addr <= REGION_BASE[23:0];
            ra_vram_dout <= ctrl_word((tile_x_max == 6'd0) && (tile_y_max == 6'd0),
                                      cont_zclear, cont_flush, 6'd0, 6'd0);
            state        <= ST_CTRL;
          end
        end
        ST_CTRL: if (accept) begin
          ra_vram_addr <= ra_vram_addr + 24'd4;
          ra_vram_dout <= list_word[LIST_O];
          state        <= ST_OPQ;
        end
        ST_OPQ: if (accept) begin
          ra_vram_addr <= ra_vram_addr + 24'd4;
          ra_vram_dout <= list_word[LIST_OM];
          state        <= ST_OPQM;
        end
        ST_OPQM: if (accept) begin
          ra_vram_addr <= ra_vram_addr + 24'd4;
          ra_vram_dout <= list_word[LIST_T];
          state        <= ST_TRN;
        end
        ST_TRN: if (accept) begin
          ra_vram_addr <= ra_vram_addr + 24'd4;
          ra_vram_dout <= list_word[LIST_TM];
          state        <= ST_TRNM;
        end
        ST_TRNM: if (accept) begin
          ra_vram_addr <= ra_vram_addr + 24'd4;
          if (fmt_v2) begin
            ra_vram_dout <= list_word[LIST_PT];
            state        <= ST_PT;
          end else begin
            ra_vram_wr <= 1'b0;
            state      <= ST_NEXT;
          end
        end
        ST_PT: if (accept) begin
          ra_vram_addr <= ra_vram_addr + 24'd4;
          ra_vram_wr   <= 1'b0;
          state        <= ST_NEXT;
        end
        // Pointers step in ra_list_ptr during this cycle, so the next
        // tile's list words are read only after the control word.
        ST_NEXT: begin
          if (last_tile) begin
            ra_gen_done <= 1'b1;
            state       <= ST_DONE;
          end else begin
            x            <= nx;
            y            <= ny;
            ra_vram_wr   <= 1'b1;
            ra_vram_dout <= ctrl_word(next_last, zclear_q, flush_q, nx, ny);
            state        <= ST_CTRL;
          end
        end
        ST_DONE: begin
          ra_gen_busy <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ra_writer.sv
// Directed and randomized runs of ra_writer, compared against a tile-grid
// reference that computes every entry from the grid/list configuration.
module tb_ra_writer;
  import ra_pkg::*;

  logic        clock;
  logic        reset;
  logic        ra_gen_trig;
  logic [31:0] REGION_BASE;
  logic [31:0] FPU_PARAM_CFG;
  logic [31:0] TA_ALLOC_CTRL;
  logic [23:0] o_list_base, om_list_base, t_list_base, tm_list_base, pt_list_base;
  logic [5:0]  tile_x_max, tile_y_max;
  logic        cont_zclear, cont_flush;
  logic        ra_vram_wr;
  logic [23:0] ra_vram_addr;
  logic [31:0] ra_vram_dout;
  logic        ra_vram_busy;
  logic        ra_gen_busy;
  logic        ra_gen_done;
  ra_state_e   dbg_state;

  int checks = 0;
  int errors = 0;

  logic [23:0] cfg_base;
  logic [7:0]  cfg_base_hi;
  logic        cfg_v2;
  logic [1:0]  cfg_opb [5];
  logic [23:0] cfg_list [5];
  int          cfg_xmax, cfg_ymax;
  logic        cfg_zc, cfg_fl;

  logic [23:0] exp_addr_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_data_q[$];

  int  n_writes;
  bit  n_done;

  ra_writer dut (
    .clock         (clock),
    .reset         (reset),
    .ra_gen_trig   (ra_gen_trig),
    .REGION_BASE   (REGION_BASE),
    .FPU_PARAM_CFG (FPU_PARAM_CFG),
    .TA_ALLOC_CTRL (TA_ALLOC_CTRL),
    .o_list_base   (o_list_base),
    .om_list_base  (om_list_base),
    .t_list_base   (t_list_base),
    .tm_list_base  (tm_list_base),
    .pt_list_base  (pt_list_base),
    .tile_x_max    (tile_x_max),
    .tile_y_max    (tile_y_max),
    .cont_zclear   (cont_zclear),
    .cont_flush    (cont_flush),
    .ra_vram_wr    (ra_vram_wr),
    .ra_vram_addr  (ra_vram_addr),
    .ra_vram_dout  (ra_vram_dout),
    .ra_vram_busy  (ra_vram_busy),
    .ra_gen_busy   (ra_gen_busy),
    .ra_gen_done   (ra_gen_done),
    .dbg_state     (dbg_state)
  );

  // Clock and reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic randomize_cfg(input int max_dim);
    cfg_base    = 24'($urandom);
    cfg_base_hi = 8'($urandom);
    cfg_v2      = 1'($urandom_range(0, 1));
    for (int t = 0; t < 5; t++) begin
      cfg_opb[t]  = 2'($urandom_range(0, 3));
      cfg_list[t] = 24'($urandom);
    end
    cfg_xmax = $urandom_range(0, max_dim);
    cfg_ymax = $urandom_range(0, max_dim);
    cfg_zc   = 1'($urandom_range(0, 1));
    cfg_fl   = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_inputs();
    REGION_BASE   = {cfg_base_hi, cfg_base};
    FPU_PARAM_CFG = ($urandom & ~32'h0020_0000) | (32'(cfg_v2) << 21);
    TA_ALLOC_CTRL = {14'b0, cfg_opb[4], 2'b0, cfg_opb[3], 2'b0, cfg_opb[2],
                     2'b0, cfg_opb[1], 2'b0, cfg_opb[0]};
    o_list_base   = cfg_list[0];
    om_list_base  = cfg_list[1];
    t_list_base   = cfg_list[2];
    tm_list_base  = cfg_list[3];
    pt_list_base  = cfg_list[4];
    tile_x_max    = 6'(cfg_xmax);
    tile_y_max    = 6'(cfg_ymax);
    cont_zclear   = cfg_zc;
    cont_flush    = cfg_fl;
  endtask

  // Reference: tile k's list pointer is base + k*stride, entries laid out back to back.
  task automatic build_model();
    int          words;
    int          k;
    logic [23:0] a;
    logic [31:0] c;
    logic [23:0] p;
    words = cfg_v2 ? 6 : 5;
    a = cfg_base;
    exp_addr_q.delete();
    exp_q.delete();
    for (int ty = 0; ty <= cfg_ymax; ty++) begin
      for (int tx = 0; tx <= cfg_xmax; tx++) begin
        k = ty * (cfg_xmax + 1) + tx;
        c = (32'(ty) << 8) | (32'(tx) << 2);
        if (tx == cfg_xmax && ty == cfg_ymax) c = c | 32'h8000_0000;
        if (cfg_zc) c = c | 32'h4000_0000;
        if (cfg_fl) c = c | 32'h1000_0000;
        exp_addr_q.push_back(a);
        exp_q.push_back(c);
        a = a + 24'd4;
        for (int t = 0; t < words - 1; t++) begin
          exp_addr_q.push_back(a);
          if (cfg_opb[t] == 2'd0) begin
            exp_q.push_back(32'h8000_0000);
          end else begin
            p = cfg_list[t] + 24'(k * (16 << cfg_opb[t]));
            exp_q.push_back({8'h00, p});
          end
          a = a + 24'd4;
        end
      end
    end
  endtask

  task automatic start_run();
    ra_vram_busy = 1'b0;
    ra_gen_trig  = 1'b1;
    @(posedge clock);
    #1;
    ra_gen_trig = 1'b0;
  endtask

  // busy_mode: 0 never busy, 1 random busy, 2 three-cycle stall on the 2nd write
  task automatic run_check(input int busy_mode, input int retrig_at, input int abort_after,
                           output int writes, output bit saw_done);
    int          cycles;
    int          stall_left;
    int          stall_cnt;
    int          total;
    bit          stalled;
    bit          finished;
    bit          abort_now;
    logic [23:0] st_addr, ea;
    logic [31:0] st_data, ed;
    cycles = 0; stall_left = 0; stall_cnt = 0;
    stalled = 0; finished = 0; abort_now = 0;
    st_addr = '0; st_data = '0;
    writes = 0; saw_done = 0;
    got_data_q.delete();
    total = (cfg_xmax + 1) * (cfg_ymax + 1) * (cfg_v2 ? 6 : 5);
    while (!finished && cycles < 4000) begin
      @(negedge clock);
      if (cycles == 0) check("busy_after_trig", 32'(ra_gen_busy), 32'd1);
      if (stalled) begin
        check("stall_wr_held", 32'(ra_vram_wr), 32'd1);
        check("stall_addr_stable", 32'(ra_vram_addr), 32'(st_addr));
        check("stall_data_stable", ra_vram_dout, st_data);
      end
      stalled = ra_vram_wr && ra_vram_busy;
      if (stalled) begin
        st_addr = ra_vram_addr;
        st_data = ra_vram_dout;
        stall_cnt++;
      end
      if (ra_vram_wr && !ra_vram_busy) begin
        writes++;
        got_data_q.push_back(ra_vram_dout);
        check("write_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          ea = exp_addr_q.pop_front();
          ed = exp_q.pop_front();
          check("write_addr", 32'(ra_vram_addr), 32'(ea));
          check("write_data", ra_vram_dout, ed);
        end
        if (busy_mode == 2 && writes == 1) stall_left = 3;
        if (writes == abort_after) abort_now = 1;
      end
      if (ra_gen_done) begin
        saw_done = 1;
        finished = 1;
      end
      @(posedge clock);
      #1;
      if (abort_now) begin
        reset    = 1'b1;
        finished = 1;
      end
      case (busy_mode)
        1: ra_vram_busy = ($urandom_range(0, 3) == 0);
        2: begin
          ra_vram_busy = (stall_left > 0);
          if (stall_left > 0) stall_left--;
        end
        default: ra_vram_busy = 1'b0;
      endcase
      ra_gen_trig = (cycles == retrig_at);
      if (cycles == retrig_at) begin
        REGION_BASE   = $urandom;
        TA_ALLOC_CTRL = $urandom;
        FPU_PARAM_CFG = $urandom;
        o_list_base   = 24'($urandom);
        tile_x_max    = 6'($urandom);
        cont_zclear   = ~cont_zclear;
      end
      cycles++;
    end
    check("run_finished", 32'(finished), 32'd1);
    if (abort_after < 0) begin
      check("write_count", 32'(writes), 32'(total));
      check("exp_drained", 32'(exp_q.size()), 32'd0);
      if (busy_mode == 2) check("stall_cycles", 32'(stall_cnt), 32'd3);
      ra_gen_trig  = 1'b0;
      ra_vram_busy = 1'b0;
      @(negedge clock);
      check("done_one_cycle", 32'(ra_gen_done), 32'd0);
      check("no_write_after_done", 32'(ra_vram_wr), 32'd0);
      check("idle_after_done", 32'(dbg_state), 32'(ST_IDLE));
      check("busy_low_after_done", 32'(ra_gen_busy), 32'd0);
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; ra_gen_trig = 1'b0; ra_vram_busy = 1'b0;
    cfg_base = '0; cfg_base_hi = '0; cfg_v2 = 1'b0; cfg_xmax = 0; cfg_ymax = 0;
    cfg_zc = 1'b0; cfg_fl = 1'b0;
    for (int t = 0; t < 5; t++) begin
      cfg_opb[t] = 2'd0;
      cfg_list[t] = '0;
    end
    drive_inputs();

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_wr", 32'(ra_vram_wr), 32'd0);
    check("rst_addr", 32'(ra_vram_addr), 32'd0);
    check("rst_dout", ra_vram_dout, 32'd0);
    check("rst_busy", 32'(ra_gen_busy), 32'd0);
    check("rst_done", 32'(ra_gen_done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clock);
    #1;
    reset = 1'b0;

    // 1x1 grid, v1, only opaque list enabled
    cfg_base = 24'h10_0000; cfg_base_hi = 8'h00; cfg_v2 = 1'b0;
    cfg_opb[0] = 2'd1; cfg_list[0] = 24'h00_0400;
    for (int t = 1; t < 5; t++) begin
      cfg_opb[t] = 2'd0;
      cfg_list[t] = 24'($urandom);
    end
    cfg_xmax = 0; cfg_ymax = 0; cfg_zc = 1'b0; cfg_fl = 1'b0;
    drive_inputs(); build_model(); start_run();
    run_check(0, -1, -1, n_writes, n_done);
    check("single_done", 32'(n_done), 32'd1);
    check("single_opq_word", got_data_q[1], 32'h0000_0400);

    // 2x2 grid, v2, every list at size code 2
    randomize_cfg(0);
    cfg_xmax = 1; cfg_ymax = 1; cfg_v2 = 1'b1;
    for (int t = 0; t < 5; t++) cfg_opb[t] = 2'd2;
    cfg_zc = 1'b0; cfg_fl = 1'b0;
    drive_inputs(); build_model(); start_run();
    run_check(1, -1, -1, n_writes, n_done);
    check("grid2_ctrl4", got_data_q[18], 32'h8000_0104);
    check("grid2_opq_tile11", got_data_q[19], {8'h00, cfg_list[0] + 24'd192});

    // Busy stall on the second write
    randomize_cfg(0);
    cfg_xmax = 1; cfg_ymax = 0;
    drive_inputs(); build_model(); start_run();
    run_check(2, -1, -1, n_writes, n_done);

    // Trigger and input changes mid-run are ignored
    randomize_cfg(0);
    cfg_xmax = 2; cfg_ymax = 1;
    drive_inputs(); build_model(); start_run();
    run_check(1, 10, -1, n_writes, n_done);

    // Reset after the 7th accepted write, then restart from REGION_BASE
    randomize_cfg(0);
    cfg_xmax = 1; cfg_ymax = 0; cfg_v2 = 1'b1;
    drive_inputs(); build_model(); start_run();
    run_check(0, -1, 7, n_writes, n_done);
    check("abort_writes", 32'(n_writes), 32'd7);
    check("abort_no_done", 32'(n_done), 32'd0);
    @(negedge clock);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("abort_wr_low", 32'(ra_vram_wr), 32'd0);
    check("abort_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("abort_busy_low", 32'(ra_gen_busy), 32'd0);
    check("abort_done_low", 32'(ra_gen_done), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive_inputs(); build_model(); start_run();
    run_check(1, -1, -1, n_writes, n_done);

    // zclear/flush on a 1x2 grid
    randomize_cfg(0);
    cfg_xmax = 0; cfg_ymax = 1; cfg_v2 = 1'b0; cfg_zc = 1'b1; cfg_fl = 1'b1;
    drive_inputs(); build_model(); start_run();
    run_check(0, -1, -1, n_writes, n_done);
    check("zf_ctrl0", got_data_q[0], 32'h5000_0000);
    check("zf_ctrl1", got_data_q[5], 32'hD000_0100);

    // Address and pointer wrap at the top of the 24-bit space
    randomize_cfg(0);
    cfg_base = 24'hFF_FFF0; cfg_base_hi = 8'hAB; cfg_v2 = 1'b1;
    cfg_xmax = 2; cfg_ymax = 0;
    for (int t = 0; t < 5; t++) begin
      cfg_opb[t] = 2'd3;
      cfg_list[t] = 24'hFF_FFC0 + 24'(t * 8);
    end
    drive_inputs(); build_model(); start_run();
    run_check(1, -1, -1, n_writes, n_done);

    // Randomized configurations
    for (int r = 0; r < 5; r++) begin
      randomize_cfg(3);
      drive_inputs(); build_model(); start_run();
      run_check(1, -1, -1, n_writes, n_done);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
